// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin EXEC/MEM writeback arbiter with registered write stage and RAW scoreboard
// Optional RF_WB_FWD_EN adds write-stage forwarding outputs for rs1/rs2.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            claim_en,
    input  logic [AW-1:0]   claim_rd,
    input  logic [AW-1:0]   rs1_sel,
    input  logic [AW-1:0]   rs2_sel,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pend_cnt,
`ifdef RF_WB_FWD_EN
    output logic            rs1_fwd_valid,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic            rs2_fwd_valid,
    output logic [XLEN-1:0] rs2_fwd_data,
`endif
    output logic            wen,
    output logic [AW-1:0]   regW_sel,
    output logic [XLEN-1:0] regW_i
);
    localparam int NR = 1 << AW;
    logic            last_q;
    logic            wen_q;
    logic [AW-1:0]   sel_q;
    logic [XLEN-1:0] data_q;
    logic [NR-1:0]   pend_q, pend_d;
    logic            ex_go, mem_go, rs1_hit, rs2_hit;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    // last_q=1 means MEM was granted last, so EXEC wins the next contention
    assign ex_go     = ex_valid & (~mem_valid | last_q);
    assign mem_go    = mem_valid & (~ex_valid | ~last_q);
    assign ex_ready  = ex_go;
    assign mem_ready = mem_go;
    assign w_rd      = ex_go ? ex_rd : mem_rd;
    assign w_data    = ex_go ? ex_data : mem_data;
    assign wen       = wen_q;
    assign regW_sel  = sel_q;
    assign regW_i    = data_q;
    assign rs1_hit   = pend_q[rs1_sel] & (rs1_sel != '0);
    assign rs2_hit   = pend_q[rs2_sel] & (rs2_sel != '0);
`ifdef RF_WB_FWD_EN
    logic f1, f2;
    assign f1            = wen_q & (sel_q == rs1_sel) & (rs1_sel != '0);
    assign f2            = wen_q & (sel_q == rs2_sel) & (rs2_sel != '0);
    assign rs1_fwd_valid = f1;
    assign rs2_fwd_valid = f2;
    assign rs1_fwd_data  = f1 ? data_q : '0;
    assign rs2_fwd_data  = f2 ? data_q : '0;
    assign rs1_busy      = rs1_hit & ~f1;
    assign rs2_busy      = rs2_hit & ~f2;
`else
    assign rs1_busy      = rs1_hit;
    assign rs2_busy      = rs2_hit;
`endif
    // a claim applied after the clear lets a new in-flight write win the same edge
    always_comb begin
        pend_d = pend_q;
        if (wen_q) pend_d[sel_q] = 1'b0;
        if (claim_en) pend_d[claim_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NR; i++) pend_cnt = pend_cnt + (AW+1)'(pend_q[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            wen_q  <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            pend_q <= '0;
        end else begin
            wen_q  <= (ex_go | mem_go) & (w_rd != '0);
            pend_q <= pend_d;
            if (ex_go | mem_go) begin
                sel_q  <= w_rd;
                data_q <= w_data;
                last_q <= mem_go;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with expected-write queue and a wen-driven monitor
module tb_regfile_wb_arbiter;
    typedef struct packed {logic [4:0] rd; logic [31:0] d;} wr_t;
    logic clk = 0, rst = 1;
    logic ex_valid = 0, mem_valid = 0, claim_en = 0;
    logic [4:0] ex_rd = 0, mem_rd = 0, claim_rd = 0, rs1_sel = 0, rs2_sel = 0;
    logic [31:0] ex_data = 0, mem_data = 0;
    logic ex_ready, mem_ready, rs1_busy, rs2_busy, wen;
    logic [5:0] pend_cnt;
    logic [4:0] regW_sel;
    logic [31:0] regW_i;
`ifdef RF_WB_FWD_EN
    logic rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
    localparam logic WC_BUSY = 1'b0;
`else
    localparam logic WC_BUSY = 1'b1;
`endif
    int checks = 0, failures = 0;
    wr_t exp_q[$];

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .claim_en(claim_en), .claim_rd(claim_rd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pend_cnt(pend_cnt),
`ifdef RF_WB_FWD_EN
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
`endif
        .wen(wen), .regW_sel(regW_sel), .regW_i(regW_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.rd = r;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_wen", {59'd0, regW_sel}, 64'h0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_sel", regW_sel, e.rd);
                chk("wr_data", regW_i, e.d);
            end
        end
    end

    always @(posedge clk)
        if (!rst && claim_en && claim_rd != 0 && dut.pend_q[claim_rd] && !(wen && regW_sel == claim_rd))
            $error("claim of already-pending register %0d", claim_rd);

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", wen, 0);
        chk("rst_sel", regW_sel, 0);
        chk("rst_data", regW_i, 0);
        chk("rst_pcnt", pend_cnt, 0);
        step();
        rst = 0;
        ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_ex_ready", ex_ready, 1);
        chk("t1_mem_ready", mem_ready, 0);
        push(5, 32'hDEADBEEF);
        step();
        ex_valid = 0;
        @(negedge clk);
        chk("t1_wen", wen, 1);
        step();
        @(negedge clk);
        chk("t1_wen_off", wen, 0);
        chk("t1_hold_sel", regW_sel, 5);
        chk("t1_hold_data", regW_i, 32'hDEADBEEF);
        step();
        mem_valid = 1; mem_rd = 0; mem_data = 32'h1234; claim_en = 1; claim_rd = 0;
        @(negedge clk);
        chk("t4_mem_ready", mem_ready, 1);
        chk("t4_ex_ready", ex_ready, 0);
        step();
        mem_valid = 0; claim_en = 0;
        @(negedge clk);
        chk("t4_wen", wen, 0);
        chk("t4_pcnt", pend_cnt, 0);
        step();
        ex_valid = 1; ex_rd = 1; ex_data = 32'hA0;
        mem_valid = 1; mem_rd = 2; mem_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_ex_grant", ex_ready, (i % 2 == 0));
            chk("t2_mem_grant", mem_ready, (i % 2 == 1));
            chk("t2_both", ex_ready & mem_ready, 0);
            if (i % 2 == 0) push(1, ex_data);
            else push(2, mem_data);
            step();
            if (i % 2 == 0) ex_data = ex_data + 1;
            else mem_data = mem_data + 1;
        end
        ex_valid = 0; mem_valid = 0;
        step();
        claim_en = 1; claim_rd = 7; rs1_sel = 7;
        @(negedge clk);
        chk("t3_busy_pre", rs1_busy, 0);
        step();
        claim_en = 0;
        @(negedge clk);
        chk("t3_busy", rs1_busy, 1);
        chk("t3_pcnt1", pend_cnt, 1);
        step();
        ex_valid = 1; ex_rd = 7; ex_data = 32'h77;
        @(negedge clk);
        chk("t3_ex_ready", ex_ready, 1);
        chk("t3_busy_xfer", rs1_busy, 1);
        push(7, 32'h77);
        step();
        ex_valid = 0;
        @(negedge clk);
        chk("t3_busy_wen", rs1_busy, WC_BUSY);
        chk("t3_pcnt_wen", pend_cnt, 1);
`ifdef RF_WB_FWD_EN
        chk("t3_fwd_valid", rs1_fwd_valid, 1);
        chk("t3_fwd_data", rs1_fwd_data, 32'h77);
`endif
        step();
        @(negedge clk);
        chk("t3_busy_clr", rs1_busy, 0);
        chk("t3_pcnt0", pend_cnt, 0);
        step();
        claim_en = 1; claim_rd = 3; rs2_sel = 3;
        step();
        claim_en = 0; ex_valid = 1; ex_rd = 3; ex_data = 32'h33;
        @(negedge clk);
        chk("t5_pcnt", pend_cnt, 1);
        chk("t5_ex_ready", ex_ready, 1);
        push(3, 32'h33);
        step();
        ex_valid = 0; claim_en = 1; claim_rd = 3;
        @(negedge clk);
        chk("t5_busy_wen", rs2_busy, WC_BUSY);
        step();
        claim_en = 0;
        @(negedge clk);
        chk("t5_busy_set_wins", rs2_busy, 1);
        chk("t5_pcnt_after", pend_cnt, 1);
        step();
        claim_en = 1; claim_rd = 4;
        step();
        claim_rd = 5;
        step();
        claim_en = 0; ex_valid = 1; ex_rd = 4; ex_data = 32'h44;
        @(negedge clk);
        chk("t6_pcnt3", pend_cnt, 3);
        chk("t6_ex_ready", ex_ready, 1);
        push(4, 32'h44);
        step();
        ex_valid = 0; rst = 1; rs1_sel = 4; rs2_sel = 5;
        @(negedge clk);
        chk("t6_busy_prerst", rs2_busy, 1);
        step();
        @(negedge clk);
        chk("t6_wen", wen, 0);
        chk("t6_pcnt", pend_cnt, 0);
        chk("t6_busy1", rs1_busy, 0);
        chk("t6_busy2", rs2_busy, 0);
        step();
        rst = 0;
`ifdef RF_WB_FWD_EN
        ex_valid = 1; ex_rd = 9; ex_data = 32'h99; rs1_sel = 9;
        @(negedge clk);
        push(9, 32'h99);
        step();
        ex_valid = 0;
        @(negedge clk);
        chk("fwd_valid", rs1_fwd_valid, 1);
        chk("fwd_data", rs1_fwd_data, 32'h99);
        chk("fwd_busy", rs1_busy, 0);
        chk("fwd_rs2_valid", rs2_fwd_valid, 0);
        chk("fwd_rs2_data", rs2_fwd_data, 0);
        step();
`endif
        repeat (2) step();
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
